// File: rtl/ram_pkg.sv
// Shared types and helpers for the parametrised scratch RAM.
package ram_pkg;

    typedef enum logic {
        CLEAR = 1'b0,
        READY = 1'b1
    } ram_state_t;

    // Address width for a power-of-two depth of at least two words.
    function automatic int addr_w(input int depth);
        return $clog2(depth);
    endfunction

endpackage

// File: rtl/ram_core.sv
// Plain storage array: one synchronous write port, one read-first registered read port.
module ram_core #(
    parameter int WIDTH  = 16,
    parameter int DEPTH  = 16,
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [WIDTH-1:0]  wdata,
    input  logic [ADDR_W-1:0] raddr,
    input  logic              rd_zero,
    output logic [WIDTH-1:0]  rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    // Non-blocking update means a same-edge read sees the old word.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        if (rd_zero) begin
            rdata <= '0;
        end else begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/ram_n.sv
// Single-port RAM with registered read and a zeroing sweep after reset or on clear.
module ram_n
    import ram_pkg::*;
#(
    parameter  int WIDTH  = 16,
    parameter  int DEPTH  = 16,
    localparam int ADDR_W = addr_w(DEPTH)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clear,
    input  logic              write,
    input  logic [ADDR_W-1:0] addr,
    input  logic [WIDTH-1:0]  in,
    output logic [WIDTH-1:0]  out,
    output logic              ready
);

    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);

    ram_state_t        state;
    logic [ADDR_W-1:0] cnt;

    logic              mem_we;
    logic [ADDR_W-1:0] mem_waddr;
    logic [WIDTH-1:0]  mem_wdata;
    logic              rd_zero;

    // Handshake: while ready is low every write/addr/in/clear is ignored and out
    // holds zero; while ready is high each edge performs one read and optional write.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= CLEAR;
            cnt   <= '0;
            ready <= 1'b0;
        end else begin
            case (state)
                CLEAR: begin
                    if (cnt == LAST) begin
                        state <= READY;
                        ready <= 1'b1;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                READY: begin
                    if (clear) begin
                        state <= CLEAR;
                        cnt   <= '0;
                        ready <= 1'b0;
                    end
                end
                default: begin
                    state <= CLEAR;
                    cnt   <= '0;
                    ready <= 1'b0;
                end
            endcase
        end
    end

    always_comb begin
        mem_we    = 1'b0;
        mem_waddr = addr;
        mem_wdata = in;
        rd_zero   = 1'b1;
        if (!reset) begin
            if (state == CLEAR) begin
                mem_we    = 1'b1;
                mem_waddr = cnt;
                mem_wdata = '0;
            end else begin
                mem_we  = write && !clear;
                rd_zero = clear;
            end
        end
    end

    ram_core #(
        .WIDTH  (WIDTH),
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_core (
        .clk     (clk),
        .we      (mem_we),
        .waddr   (mem_waddr),
        .wdata   (mem_wdata),
        .raddr   (addr),
        .rd_zero (rd_zero),
        .rdata   (out)
    );

endmodule

// File: tb/tb_ram_n.sv
// Directed bench for ram_n: a 16x16 instance and an 8-bit, 2-word corner instance.
module tb_ram_n;

    logic clk;

    // Default 16x16 instance.
    logic        reset, clear, write;
    logic [3:0]  addr;
    logic [15:0] in, out;
    logic        ready;

    // WIDTH=8, DEPTH=2 instance.
    logic        s_reset, s_clear, s_write;
    logic [0:0]  s_addr;
    logic [7:0]  s_in, s_out;
    logic        s_ready;

    int n_vec = 0;
    int n_err = 0;

    ram_n dut (
        .clk   (clk),
        .reset (reset),
        .clear (clear),
        .write (write),
        .addr  (addr),
        .in    (in),
        .out   (out),
        .ready (ready)
    );

    ram_n #(.WIDTH(8), .DEPTH(2)) dut_s (
        .clk   (clk),
        .reset (s_reset),
        .clear (s_clear),
        .write (s_write),
        .addr  (s_addr),
        .in    (s_in),
        .out   (s_out),
        .ready (s_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [3:0] a, input logic [15:0] d);
        addr  = a;
        in    = d;
        write = 1'b1;
        tick();
        write = 1'b0;
    endtask

    task automatic rd(input logic [3:0] a, input logic [15:0] exp, input string tag);
        addr  = a;
        write = 1'b0;
        tick();
        check(tag, out, exp);
    endtask

    // Counts the sweep: ready stays low for DEPTH-1 edges, rises on the DEPTH-th.
    task automatic sweep16(input string tag);
        for (int i = 1; i <= 15; i++) begin
            tick();
            check({tag, "_ready_low"}, {15'd0, ready}, 16'd0);
            check({tag, "_out_zero"}, out, 16'h0000);
        end
        tick();
        check({tag, "_ready_high"}, {15'd0, ready}, 16'd1);
    endtask

    task automatic s_rd(input logic a, input logic [7:0] exp, input string tag);
        s_addr  = a;
        s_write = 1'b0;
        tick();
        check(tag, {8'd0, s_out}, {8'd0, exp});
    endtask

    initial begin
        reset = 1'b0; clear = 1'b0; write = 1'b0; addr = '0; in = '0;
        s_reset = 1'b1; s_clear = 1'b0; s_write = 1'b0; s_addr = '0; s_in = '0;
        #1;

        // Reset then full sweep.
        reset = 1'b1;
        tick();
        check("rst_ready", {15'd0, ready}, 16'd0);
        check("rst_out", out, 16'h0000);
        reset = 1'b0;
        sweep16("init");
        for (int a = 0; a < 16; a++) rd(4'(a), 16'h0000, "init_zero");

        // Basic write/read.
        wr(4'd5, 16'hBEEF);
        rd(4'd5, 16'hBEEF, "wr5_rd5");
        rd(4'd4, 16'h0000, "rd4_untouched");

        // Read-first collision.
        wr(4'd3, 16'h1111);
        addr = 4'd3; in = 16'h2222; write = 1'b1;
        tick();
        write = 1'b0;
        check("collide_old", out, 16'h1111);
        rd(4'd3, 16'h2222, "collide_new");

        // Runtime clear with a simultaneous write that must be dropped.
        for (int a = 0; a < 16; a++) wr(4'(a), 16'hA5A5);
        rd(4'd7, 16'hA5A5, "fill_a5");
        rd(4'd0, 16'hA5A5, "fill_a5_0");
        clear = 1'b1; write = 1'b1; addr = 4'd0; in = 16'hFFFF;
        tick();
        clear = 1'b0; write = 1'b0;
        check("clr_ready_drop", {15'd0, ready}, 16'd0);
        check("clr_out_zero", out, 16'h0000);
        sweep16("clr");
        for (int a = 0; a < 16; a++) rd(4'(a), 16'h0000, "clr_zero");

        // Reset mid-sweep, with writes ignored while sweeping.
        wr(4'd9, 16'h5A5A);
        clear = 1'b1;
        tick();
        clear = 1'b0;
        for (int i = 0; i < 7; i++) begin
            write = 1'b1; addr = 4'd9; in = 16'h1234;
            tick();
            check("mid_out_zero", out, 16'h0000);
            check("mid_ready_low", {15'd0, ready}, 16'd0);
        end
        write = 1'b0;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("mid_rst_ready", {15'd0, ready}, 16'd0);
        sweep16("mid");
        rd(4'd9, 16'h0000, "mid_wr_ignored");

        // Parameter corner: WIDTH=8, DEPTH=2.
        tick();
        s_reset = 1'b0;
        tick();
        check("s_ready_e1", {15'd0, s_ready}, 16'd0);
        tick();
        check("s_ready_e2", {15'd0, s_ready}, 16'd1);
        s_addr = 1'b1; s_in = 8'h7F; s_write = 1'b1;
        tick();
        s_addr = 1'b0; s_in = 8'h80;
        tick();
        s_write = 1'b0;
        s_rd(1'b1, 8'h7F, "s_rd1");
        s_rd(1'b0, 8'h80, "s_rd0");
        s_clear = 1'b1;
        tick();
        s_clear = 1'b0;
        check("s_clr_drop", {15'd0, s_ready}, 16'd0);
        tick();
        check("s_clr_e1", {15'd0, s_ready}, 16'd0);
        tick();
        check("s_clr_e2", {15'd0, s_ready}, 16'd1);
        s_rd(1'b1, 8'h00, "s_clr_rd1");
        s_rd(1'b0, 8'h00, "s_clr_rd0");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
